clock_div_multi: RTL and testbench
==================================

CLOCK_DIV_MULTI -- requirements
Module: clock_div_multi

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, input clock frequency in Hz.
REQ-002 Parameter OUT_FREQ, default 1000000, reset-time output frequency in Hz for every channel.
REQ-003 Parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-004 Parameter DIV_W, default 32, divisor width in bits.
REQ-005 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 ch_enable  input  NUM_CH  per-channel run enable, level-sensitive.
REQ-008 sync_restart  input  1  single-cycle pulse; realigns the phase of all channels.
REQ-009 cfg_valid  input  1  divisor write request.
REQ-010 cfg_ready  output  1  write accepted in any cycle where cfg_valid and cfg_ready are both high.
REQ-011 cfg_ch  input  max(1,$clog2(NUM_CH))  target channel; values >= NUM_CH are accepted and discarded.
REQ-012 cfg_div  input  DIV_W  new period in clk_in cycles.
REQ-013 clk_out  output  NUM_CH  per-channel divided square wave, registered.
REQ-014 tick  output  NUM_CH  per-channel one-cycle strobe at the start of each period, registered.

Function
REQ-015 Each channel holds an active divisor N, a pending divisor P, a pending flag F and a counter cnt (DIV_W bits).
REQ-016 Effective divisor = max(value, 2); writes of 0 or 1 are stored as 2.
REQ-017 Running channel: cnt counts 0..N-1, then wraps to 0.
REQ-018 tick[i] is high exactly in cycles where the channel is running and cnt == 0.
REQ-019 clk_out[i] is high while running and cnt < (N+1)/2, otherwise low; odd N gives one extra high cycle.
REQ-020 ch_enable[i] low: cnt held at 0, clk_out[i]=0, tick[i]=0.
REQ-021 ch_enable[i] rising in cycle k: cnt=0 in cycle k+1, so tick[i] and clk_out[i] are high in cycle k+1.
REQ-022 cfg_ready = ~F[cfg_ch]; any out-of-range cfg_ch gives cfg_ready=1.
REQ-023 An accepted write sets P=cfg_div (clamped) and F=1.
REQ-024 A pending update is applied (N<=P, F<=0) on the cycle cnt wraps from N-1 to 0, so no runt or stretched period is emitted.
REQ-025 A pending update on a disabled channel is applied on the next cycle.
REQ-026 A write accepted in the same cycle as a wrap becomes pending; it is applied at the following wrap.
REQ-027 sync_restart in cycle k: every channel sets cnt=0 in k+1 and applies any pending update at that point; enabled channels tick in k+1.
REQ-028 sync_restart coinciding with a wrap or enable edge: the restart result (cnt=0) governs; the other behaviours are not additive.
REQ-029 Counter compare is full DIV_W width; cnt never exceeds N-1, including when N shrinks while an update is pending.

Reset
REQ-030 While resetn is low: N=DEFAULT_DIV, F=0, P=DEFAULT_DIV, cnt=0, clk_out=0, tick=0, cfg_ready=1.
REQ-031 DEFAULT_DIV = max(CLK_FREQ/OUT_FREQ, 2); elaboration fails if OUT_FREQ > CLK_FREQ/2.
REQ-032 Reset asserted mid-period forces outputs low immediately and discards pending writes.
REQ-033 After reset deassertion, an enabled channel starts at cnt=0 on the first clk_in edge.

Structure
REQ-034 Package clock_div_pkg holds MIN_DIV=2, the clamp function and the DEFAULT_DIV computation.
REQ-035 Sub-module clock_div_channel implements one channel (N, P, F, cnt, outputs) and is instantiated NUM_CH times; the top level holds only decode and cfg_ready muxing.

Verification
REQ-036 Defaults: release reset with ch_enable=4'hF -> every tick period is 100 cycles and clk_out is high for 50 cycles and low for 50, on all channels.
REQ-037 Odd divisor: write ch1 div=5 mid-period -> the current 100-cycle period completes, then clk_out[1] is high 3 and low 2 with tick every 5 cycles.
REQ-038 Back-pressure: back-to-back writes to ch0 (div=10, then 20) -> cfg_ready is low after the first write until the wrap; the second write is accepted next, and periods run 100, 10, 20.
REQ-039 Clamp: write div=0 and div=1 on ch2 -> period 2 with clk_out toggling every cycle.
REQ-040 Restart: ch0 div=3 and ch1 div=4 misaligned, pulse sync_restart -> both tick in the next cycle, then tick coincidently every 12 cycles.
REQ-041 Reset mid-operation: drop resetn while pending F=1 and cnt=37 -> outputs go 0 asynchronously; after release, the period is 100 and the pending value is lost.

Source files
------------

// File: rtl/clock_div_pkg.sv
// rtl/clock_div_pkg.sv - shared constants and helpers for the multi-channel clock divider
package clock_div_pkg;

  localparam int unsigned MIN_DIV = 2;

  function automatic logic [63:0] clamp_div(input logic [63:0] div);
    return (div < 64'(MIN_DIV)) ? 64'(MIN_DIV) : div;
  endfunction

  // A zero output frequency is rejected at elaboration; guard the divide anyway.
  function automatic logic [63:0] calc_default_div(input logic [63:0] clk_freq,
                                                   input logic [63:0] out_freq);
    return (out_freq == 64'd0) ? 64'(MIN_DIV) : clamp_div(clk_freq / out_freq);
  endfunction

endpackage

// File: rtl/clock_div_channel.sv
// rtl/clock_div_channel.sv - one divider channel: active/pending divisor, counter, registered outputs
module clock_div_channel
  import clock_div_pkg::*;
#(
  parameter int               DIV_W       = 32,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(MIN_DIV)
) (
  input  logic             clk_in,
  input  logic             resetn,
  input  logic             enable_i,
  input  logic             restart_i,
  input  logic             wr_en_i,
  input  logic [DIV_W-1:0] wr_div_i,
  output logic             pending_o,
  output logic             clk_out_o,
  output logic             tick_o
);

  logic [DIV_W-1:0] n_q, n_d, p_q, p_d, cnt_q, cnt_d;
  logic             f_q, f_d, en_q;
  logic             clk_out_q, clk_out_d, tick_q, tick_d;
  logic             wrap, apply;
  logic [DIV_W:0]   half;

  always_comb begin
    wrap  = en_q && enable_i && (cnt_q >= n_q - DIV_W'(1));
    // New divisor only takes effect where a period starts, or at once when idle.
    apply = f_q && (restart_i || wrap || !en_q);
    n_d   = apply ? p_q : n_q;
    p_d   = p_q;
    f_d   = f_q;
    if (apply) f_d = 1'b0;
    if (wr_en_i && !f_q) begin
      p_d = DIV_W'(clamp_div(64'(wr_div_i)));
      f_d = 1'b1;
    end
    if (restart_i || !enable_i || !en_q || wrap) cnt_d = '0;
    else                                         cnt_d = cnt_q + DIV_W'(1);
    half      = ({1'b0, n_d} + (DIV_W + 1)'(1)) >> 1;
    tick_d    = enable_i && (cnt_d == '0);
    clk_out_d = enable_i && ({1'b0, cnt_d} < half);
  end

  always_ff @(posedge clk_in or negedge resetn) begin
    if (!resetn) begin
      n_q       <= DEFAULT_DIV;
      p_q       <= DEFAULT_DIV;
      f_q       <= 1'b0;
      cnt_q     <= '0;
      en_q      <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      n_q       <= n_d;
      p_q       <= p_d;
      f_q       <= f_d;
      cnt_q     <= cnt_d;
      en_q      <= enable_i;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign pending_o = f_q;
  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clock_div_multi.sv
// rtl/clock_div_multi.sv - multi-channel programmable clock divider: config decode and channel array
module clock_div_multi
  import clock_div_pkg::*;
#(
  parameter longint unsigned CLK_FREQ = 100000000,
  parameter longint unsigned OUT_FREQ = 1000000,
  parameter int              NUM_CH   = 4,
  parameter int              DIV_W    = 32,
  localparam int             CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              resetn,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              sync_restart,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(calc_default_div(64'(CLK_FREQ), 64'(OUT_FREQ)));

  if (OUT_FREQ == 0 || OUT_FREQ > CLK_FREQ / 2) begin : g_bad_freq
    $error("clock_div_multi: OUT_FREQ must lie in 1..CLK_FREQ/2");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("clock_div_multi: NUM_CH must lie in 1..16");
  end

  logic [NUM_CH-1:0] sel, pend;

  // Out-of-range cfg_ch matches no channel, so it reads as ready and is dropped.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign sel[i] = (cfg_ch == CH_W'(i));
    clock_div_channel #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk_in   (clk_in),
      .resetn   (resetn),
      .enable_i (ch_enable[i]),
      .restart_i(sync_restart),
      .wr_en_i  (cfg_valid && cfg_ready && sel[i]),
      .wr_div_i (cfg_div),
      .pending_o(pend[i]),
      .clk_out_o(clk_out[i]),
      .tick_o   (tick[i])
    );
  end

  assign cfg_ready = ~|(sel & pend);

endmodule

// File: tb/tb_clock_div_multi.sv
// tb/tb_clock_div_multi.sv - scoreboard bench for clock_div_multi
module tb_clock_div_multi;

  typedef struct {
    int per;
    int hi;
  } exp_t;

  logic        clk_in = 1'b0;
  logic        resetn;
  logic [3:0]  ch_enable;
  logic        sync_restart;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_div;
  logic [3:0]  clk_out;
  logic [3:0]  tick;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[4][$];
  int   last_t[4];
  bit   have[4];
  int   hi[4];

  clock_div_multi dut (
    .clk_in      (clk_in),
    .resetn      (resetn),
    .ch_enable   (ch_enable),
    .sync_restart(sync_restart),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .clk_out     (clk_out),
    .tick        (tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Measures each completed period (tick to tick) and its high time, against the scoreboard.
  always @(negedge clk_in) begin : mon
    exp_t e;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (!resetn) begin
        have[i] = 1'b0;
        hi[i]   = 0;
      end else begin
        if (tick[i]) begin
          if (have[i] && exp_q[i].size() > 0) begin
            e = exp_q[i].pop_front();
            check_eq($sformatf("ch%0d_period", i), cyc - last_t[i], e.per);
            check_eq($sformatf("ch%0d_high", i), hi[i], e.hi);
          end
          have[i]   = 1'b1;
          last_t[i] = cyc;
          hi[i]     = 0;
        end
        if (clk_out[i]) hi[i]++;
      end
    end
  end

  task automatic push_exp(input int ch, input int per, input int h, input int n);
    exp_t e;
    e.per = per;
    e.hi  = h;
    for (int k = 0; k < n; k++) exp_q[ch].push_back(e);
  endtask

  task automatic wait_tick(input int ch);
    int t = 0;
    @(negedge clk_in);
    while (!tick[ch] && t < 300) begin
      @(negedge clk_in);
      t++;
    end
    check_eq($sformatf("tick_seen_ch%0d", ch), tick[ch], 1);
    #1;
  endtask

  task automatic wait_drain(input string tag, input int max_cyc);
    int t = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
           && t < max_cyc) begin
      @(negedge clk_in);
      t++;
    end
    #1;
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("%s_drain_ch%0d", tag, i), exp_q[i].size(), 0);
  endtask

  task automatic cfg_write(input int ch, input int div);
    int t = 0;
    @(negedge clk_in);
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_div   = 32'(div);
    while (!cfg_ready && t < 500) begin
      @(negedge clk_in);
      t++;
    end
    check_eq($sformatf("cfg_accept_ch%0d", ch), cfg_ready, 1);
    @(negedge clk_in);
    cfg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn       = 1'b0;
    ch_enable    = 4'hF;
    sync_restart = 1'b0;
    cfg_valid    = 1'b0;
    cfg_ch       = 2'd0;
    cfg_div      = 32'd0;

    repeat (3) @(negedge clk_in);
    check_eq("rst_clk_out", clk_out, 0);
    check_eq("rst_tick", tick, 0);
    check_eq("rst_cfg_ready", cfg_ready, 1);

    // Defaults: 100-cycle periods, 50 high, first tick right after the first edge.
    resetn = 1'b1;
    @(negedge clk_in);
    check_eq("start_tick", tick, 4'hF);
    check_eq("start_clk_out", clk_out, 4'hF);
    #1;
    for (int i = 0; i < 4; i++) push_exp(i, 100, 50, 2);
    wait_drain("default", 400);

    // Odd divisor written mid-period on ch1.
    wait_tick(1);
    push_exp(1, 100, 50, 1);
    push_exp(1, 5, 3, 3);
    repeat (10) @(negedge clk_in);
    cfg_write(1, 5);
    wait_drain("odd", 300);

    // Back-pressure on ch0.
    wait_tick(0);
    push_exp(0, 100, 50, 1);
    push_exp(0, 10, 5, 1);
    push_exp(0, 20, 10, 1);
    repeat (10) @(negedge clk_in);
    cfg_write(0, 10);
    check_eq("bp_ready_low", cfg_ready, 0);
    cfg_write(0, 20);
    wait_drain("backpressure", 400);

    // Clamp of 0 and 1 on ch2.
    wait_tick(2);
    push_exp(2, 100, 50, 1);
    push_exp(2, 2, 1, 3);
    cfg_write(2, 0);
    cfg_write(2, 1);
    wait_drain("clamp", 400);

    // Restart realigns ch0 (3) and ch1 (4).
    cfg_write(0, 3);
    cfg_write(1, 4);
    repeat (7) @(negedge clk_in);
    sync_restart = 1'b1;
    @(negedge clk_in);
    sync_restart = 1'b0;
    check_eq("restart_tick", tick, 4'hF);
    #1;
    push_exp(0, 3, 2, 4);
    push_exp(1, 4, 2, 3);
    repeat (6) @(negedge clk_in);
    check_eq("restart_tick_6", tick[1:0], 2'b01);
    repeat (6) @(negedge clk_in);
    check_eq("restart_tick_12", tick[1:0], 2'b11);
    wait_drain("restart", 100);

    // Asynchronous reset with a pending write on ch3.
    wait_tick(3);
    repeat (36) @(negedge clk_in);
    cfg_write(3, 7);
    check_eq("pend_ready_low", cfg_ready, 0);
    check_eq("pre_rst_clk_out3", clk_out[3], 1);
    #2;
    resetn = 1'b0;
    #1;
    check_eq("async_rst_clk_out", clk_out, 0);
    check_eq("async_rst_tick", tick, 0);
    check_eq("async_rst_ready", cfg_ready, 1);
    repeat (3) @(negedge clk_in);
    resetn = 1'b1;
    @(negedge clk_in);
    check_eq("rerelease_tick", tick, 4'hF);
    #1;
    for (int i = 0; i < 4; i++) push_exp(i, 100, 50, 2);
    wait_drain("post_reset", 400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
